// File: rtl/div32_seq_ctrl_pkg.sv
// Shared definitions for the sequential 32-bit unsigned divider:
// operand/counter widths, iteration count, the divide-by-zero quotient,
// the FSM state encoding and the result payload struct.
package div32_seq_ctrl_pkg;

    localparam int unsigned DIV_W     = 32;
    localparam int unsigned DIV_CNT_W = 6;
    localparam int unsigned DIV_ITERS = 32;

    localparam logic [DIV_W-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

    // 2'b11 is unused; the FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    typedef struct packed {
        logic [DIV_W-1:0] quotient;
        logic [DIV_W-1:0] remainder;
        logic             div_by_zero;
    } div_rsp_t;

endpackage

// File: rtl/div32_seq_ctrl_if.sv
// Request/response bundle of the divider.
// master: operand producer / result consumer. slave: the divider.
//   in_valid/in_ready + dividend/divisor : request handshake
//   out_valid/out_ready + quotient/remainder/div_by_zero : result handshake
//   busy : divider not idle
interface div32_seq_ctrl_if;
    import div32_seq_ctrl_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [DIV_W-1:0] dividend;
    logic [DIV_W-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [DIV_W-1:0] quotient;
    logic [DIV_W-1:0] remainder;
    logic             div_by_zero;
    logic             busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, busy
    );

endinterface

// File: rtl/div32_seq_ctrl_sub32_unit.sv
// Purely combinational 32-bit subtractor: {cout, diff} = a + ~b + 1.
// cout=1 means a >= b (no borrow).
//   a, b : operands
//   diff : a - b modulo 2^32
//   cout : carry out of the adder
module sub32_unit
    import div32_seq_ctrl_pkg::*;
(
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    output logic [DIV_W-1:0] diff,
    output logic             cout
);

    logic [DIV_W-1:0] b_n;

    assign b_n = ~b;

    // Adder with carry-in of one completes the two's-complement negate.
    assign {cout, diff} = {1'b0, a} + {1'b0, b_n} + (DIV_W+1)'(1);

endmodule

// File: rtl/div32_seq_ctrl.sv
// Sequential 32-bit unsigned restoring divider: one quotient bit per cycle
// through a shared subtractor, valid/ready on request and result.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : request/response bundle (slave side)
module div32_seq_ctrl
    import div32_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_W,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    div32_seq_ctrl_if.slave  bus
);

    if (WIDTH != DIV_W) begin : g_bad_width
        $error("div32_seq_ctrl: only WIDTH=32 is supported");
    end
    if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt_w
        $error("div32_seq_ctrl: CNT_W too small to count WIDTH iterations");
    end

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    div_rsp_t         rsp_q, rsp_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] diff;
    logic             cout;
    logic             take;

    // Shifted partial remainder; its top bit forces a take because S >= 2^32 > D.
    assign s    = {r_q, q_q[WIDTH-1]};
    assign take = s[WIDTH] | cout;

    sub32_unit u_sub (
        .a    (s[WIDTH-1:0]),
        .b    (d_q),
        .diff (diff),
        .cout (cout)
    );

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            q_q         <= '0;
            r_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            rsp_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            d_q         <= d_d;
            cnt_q       <= cnt_d;
            rsp_q       <= rsp_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        rsp_d   = rsp_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    d_d   = bus.divisor;
                    q_d   = bus.dividend;
                    r_d   = '0;
                    cnt_d = '0;
                    if (bus.divisor == '0) begin
                        state_d           = ST_DONE;
                        rsp_d.quotient    = DIV0_QUOT;
                        rsp_d.remainder   = bus.dividend;
                        rsp_d.div_by_zero = 1'b1;
                    end else begin
                        state_d           = ST_RUN;
                        rsp_d.div_by_zero = 1'b0;
                    end
                end
            end
            ST_RUN: begin
                if (take) begin
                    r_d = diff;
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = s[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                    state_d         = ST_DONE;
                    rsp_d.quotient  = q_d;
                    rsp_d.remainder = r_d;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.busy        = busy_q;
    assign bus.quotient    = rsp_q.quotient;
    assign bus.remainder   = rsp_q.remainder;
    assign bus.div_by_zero = rsp_q.div_by_zero;

endmodule

// File: tb/tb_div32_seq_ctrl.sv
// Self-checking bench for div32_seq_ctrl: directed cases plus random
// operands compared against plain '/' and '%' arithmetic.
module tb_div32_seq_ctrl;
    import div32_seq_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    div32_seq_ctrl_if bus ();

    div32_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},  32'(bus.in_ready),    32'd1);
        check({tag, "_ov"},   32'(bus.out_valid),   32'd0);
        check({tag, "_busy"}, 32'(bus.busy),        32'd0);
        check({tag, "_q"},    bus.quotient,         32'd0);
        check({tag, "_r"},    bus.remainder,        32'd0);
        check({tag, "_dbz"},  32'(bus.div_by_zero), 32'd0);
    endtask

    // One complete operation: accept, measure latency, check result,
    // hold out_ready low for 'hold' cycles (with an ignored request), hand off.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_z;
        int          exp_lat;
        int          n;

        exp_z   = (b == 32'd0);
        exp_q   = exp_z ? 32'hFFFF_FFFF : a / b;
        exp_r   = exp_z ? a : a % b;
        exp_lat = exp_z ? 1 : 33;

        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rdy_pre", 32'(bus.in_ready), 32'd1);

        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        check("rdy_acc", 32'(bus.in_ready), 32'd0);

        n = 1;
        while (!bus.out_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(exp_lat));
        check("quot",    bus.quotient,         exp_q);
        check("rem",     bus.remainder,        exp_r);
        check("dbz",     32'(bus.div_by_zero), 32'(exp_z));

        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 32'd77;
            bus.divisor  = 32'd3;
            @(posedge clk); #1;
            check("hold_ov",   32'(bus.out_valid), 32'd1);
            check("hold_rdy",  32'(bus.in_ready),  32'd0);
            check("hold_busy", 32'(bus.busy),      32'd1);
            check("hold_q",    bus.quotient,       exp_q);
            check("hold_r",    bus.remainder,      exp_r);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_ov",   32'(bus.out_valid), 32'd0);
        check("post_rdy",  32'(bus.in_ready),  32'd1);
        check("post_busy", 32'(bus.busy),      32'd0);
        check("post_q",    bus.quotient,       exp_q);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'd100, 32'd7, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(32'd7, 32'd9, 0);
        run_op(32'h8000_0000, 32'h8000_0001, 0);
        run_op(32'd5, 32'd0, 2);
        run_op(32'd1000, 32'd10, 10);

        // Reset in the middle of RUN, after the count==15 iteration state is reached.
        bus.in_valid = 1'b1;
        bus.dividend = 32'd123456789;
        bus.divisor  = 32'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        check_reset_outputs("midrst_hold");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_rdy_rel", 32'(bus.in_ready),  32'd1);
        check("midrst_ov_rel",  32'(bus.out_valid), 32'd0);
        run_op(32'd50, 32'd3, 0);

        for (int k = 0; k < 40; k++) begin
            ra = $urandom >> $urandom_range(0, 31);
            case ($urandom_range(0, 7))
                0, 1, 2: rb = $urandom;
                3, 4:    rb = 32'($urandom_range(1, 255));
                5:       rb = ra;
                6:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = 32'd0;
            endcase
            run_op(ra, rb, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
